// File: rtl/dx_hazard_reg_pkg.sv
// rtl/dx_hazard_reg_pkg.sv - opcode constants, NOP encoding and register-use helpers
package dx_hazard_reg_pkg;

    localparam logic [4:0]  OPC_LOAD   = 5'b00000;
    localparam logic [4:0]  OPC_STORE  = 5'b01000;
    localparam logic [4:0]  OPC_BRANCH = 5'b11000;
    localparam logic [4:0]  OPC_OP     = 5'b01100;
    localparam logic [4:0]  OPC_LUI    = 5'b01101;
    localparam logic [4:0]  OPC_AUIPC  = 5'b00101;
    localparam logic [4:0]  OPC_JAL    = 5'b11011;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    // Takes opcode[6:2]; formats without an rs1 field leave garbage in bits 19:15
    function automatic logic rs1_used(input logic [4:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    // Takes opcode[6:2]; only R, S and B formats carry a real rs2
    function automatic logic rs2_used(input logic [4:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_OP || opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/dx_hazard_reg_if.sv
// rtl/dx_hazard_reg_if.sv - D->X pipeline register signal bundle
interface dx_hazard_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  d_pc;
    logic [XLEN-1:0]  d_inst;
    logic             d_valid;
    logic             x_br_taken;
    logic             stall;
    logic             flush_fd;
    logic [XLEN-1:0]  x_pc;
    logic [XLEN-1:0]  x_inst;
    logic             x_valid;
    logic [6:0]       x_opcode;
    logic [4:0]       x_rd;
    logic [4:0]       x_rs1;
    logic [4:0]       x_rs2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output d_pc, d_inst, d_valid, x_br_taken,
        input  stall, flush_fd, x_pc, x_inst, x_valid,
               x_opcode, x_rd, x_rs1, x_rs2, stall_cnt, flush_cnt
    );

    modport slave (
        input  d_pc, d_inst, d_valid, x_br_taken,
        output stall, flush_fd, x_pc, x_inst, x_valid,
               x_opcode, x_rd, x_rs1, x_rs2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/dx_hazard_reg_sat_counter.sv
// rtl/dx_hazard_reg_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc and stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dx_hazard_reg.sv
// rtl/dx_hazard_reg.sv - D->X pipeline register with load-use stall and branch flush
module dx_hazard_reg
    import dx_hazard_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dx_hazard_reg_if.slave bus
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

    logic [XLEN-1:0]  x_inst_q;
    logic [XLEN-1:0]  x_pc_q;
    logic             x_valid_q;
    logic [4:0]       d_opc;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic             lu_haz;
    logic             stall_int;
    logic [CNT_W-1:0] stall_cnt_w;
    logic [CNT_W-1:0] flush_cnt_w;

    assign d_opc = bus.d_inst[6:2];
    assign d_rs1 = bus.d_inst[19:15];
    assign d_rs2 = bus.d_inst[24:20];

    // Load in X whose destination D reads; x0 never creates a dependency
    always_comb begin
        lu_haz = 1'b0;
        if (x_valid_q && bus.d_valid && (x_inst_q[6:2] == OPC_LOAD) && (x_inst_q[11:7] != 5'd0)) begin
            lu_haz = (rs1_used(d_opc) && (d_rs1 == x_inst_q[11:7])) ||
                     (rs2_used(d_opc) && (d_rs2 == x_inst_q[11:7]));
        end
    end

    // Flush wins over stall; both held low while in reset
    assign stall_int    = rst_n && lu_haz && !bus.x_br_taken;
    assign bus.stall    = stall_int;
    assign bus.flush_fd = rst_n && bus.x_br_taken;

    // X register: bubble on flush or load-use, otherwise take D
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_inst_q  <= NOP;
            x_pc_q    <= '0;
            x_valid_q <= 1'b0;
        end else if (bus.x_br_taken || lu_haz) begin
            x_inst_q  <= NOP;
            x_pc_q    <= '0;
            x_valid_q <= 1'b0;
        end else begin
            x_inst_q  <= bus.d_valid ? bus.d_inst : NOP;
            x_pc_q    <= bus.d_pc;
            x_valid_q <= bus.d_valid;
        end
    end

    assign bus.x_inst   = x_inst_q;
    assign bus.x_pc     = x_pc_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.x_opcode = x_inst_q[6:0];
    assign bus.x_rd     = x_inst_q[11:7];
    assign bus.x_rs1    = x_inst_q[19:15];
    assign bus.x_rs2    = x_inst_q[24:20];

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_int),
        .count (stall_cnt_w)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.x_br_taken),
        .count (flush_cnt_w)
    );

    assign bus.stall_cnt = stall_cnt_w;
    assign bus.flush_cnt = flush_cnt_w;

endmodule

// File: tb/tb_dx_hazard_reg.sv
// tb/tb_dx_hazard_reg.sv - self-checking bench for dx_hazard_reg
module tb_dx_hazard_reg;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LW5   = 32'h0000_A283;
    localparam logic [31:0] ADD5  = 32'h0072_8333;
    localparam logic [31:0] LW0   = 32'h0000_2003;
    localparam logic [31:0] ADD0  = 32'h0070_0333;
    localparam logic [31:0] ADDI  = 32'h0050_0313;
    localparam logic [31:0] SW5   = 32'h0051_2023;
    localparam logic [31:0] LUI   = 32'h0002_83B7;
    localparam logic [31:0] BEQ5  = 32'h0050_0063;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n2;
    always #5 clk = ~clk;

    dx_hazard_reg_if #(.XLEN(32), .CNT_W(32)) bus  ();
    dx_hazard_reg_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    dx_hazard_reg #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    dx_hazard_reg #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n2), .bus(bus2));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        br;
        logic        e_stall;
        logic        e_flush;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_valid;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] pc, input logic [31:0] inst, input logic valid,
                           input logic br, input logic es, input logic ef,
                           input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        vec_t v;
        v.pc = pc; v.inst = inst; v.valid = valid; v.br = br;
        v.e_stall = es; v.e_flush = ef; v.e_inst = ei; v.e_pc = ep; v.e_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic [1:0]  sat_exp;

        rst_n = 1'b0; rst_n2 = 1'b0;
        bus.d_pc = 32'h0; bus.d_inst = ADD5; bus.d_valid = 1'b1; bus.x_br_taken = 1'b0;
        bus2.d_pc = 32'h0; bus2.d_inst = NOP; bus2.d_valid = 1'b0; bus2.x_br_taken = 1'b0;

        // Reset held for two edges with a valid instruction presented on D
        repeat (2) @(posedge clk);
        #1;
        chk("reset x_inst",  bus.x_inst,  NOP);
        chk("reset x_valid", bus.x_valid, 0);
        chk("reset x_pc",    bus.x_pc,    0);
        chk("reset stall",   bus.stall,   0);
        chk("reset flush",   bus.flush_fd, 0);
        chk("reset stall_cnt", bus.stall_cnt, 0);
        chk("reset flush_cnt", bus.flush_cnt, 0);

        //       pc        inst  v   br  stl fl  next x_inst  next pc   next v
        add_vec(32'h100, LW5,  1, 0, 0, 0, LW5,  32'h100, 1);
        add_vec(32'h104, ADD5, 1, 0, 1, 0, NOP,  32'h0,   0);
        add_vec(32'h104, ADD5, 1, 0, 0, 0, ADD5, 32'h104, 1);
        add_vec(32'h108, LW0,  1, 0, 0, 0, LW0,  32'h108, 1);
        add_vec(32'h10C, ADD0, 1, 0, 0, 0, ADD0, 32'h10C, 1);
        add_vec(32'h110, LW5,  1, 0, 0, 0, LW5,  32'h110, 1);
        add_vec(32'h114, ADDI, 1, 0, 0, 0, ADDI, 32'h114, 1);
        add_vec(32'h118, LW5,  1, 0, 0, 0, LW5,  32'h118, 1);
        add_vec(32'h11C, ADD5, 1, 1, 0, 1, NOP,  32'h0,   0);
        add_vec(32'h200, 32'h1234_5678, 0, 0, 0, 0, NOP, 32'h200, 0);
        add_vec(32'h120, LW5,  1, 0, 0, 0, LW5,  32'h120, 1);
        add_vec(32'h124, SW5,  1, 0, 1, 0, NOP,  32'h0,   0);
        add_vec(32'h124, SW5,  1, 0, 0, 0, SW5,  32'h124, 1);
        add_vec(32'h128, LW5,  1, 0, 0, 0, LW5,  32'h128, 1);
        add_vec(32'h12C, LUI,  1, 0, 0, 0, LUI,  32'h12C, 1);
        add_vec(32'h130, LW5,  1, 0, 0, 0, LW5,  32'h130, 1);
        add_vec(32'h134, BEQ5, 1, 0, 1, 0, NOP,  32'h0,   0);
        add_vec(32'h134, BEQ5, 1, 0, 0, 0, BEQ5, 32'h134, 1);
        add_vec(32'h140, LW5,  1, 0, 0, 0, LW5,  32'h140, 1);
        add_vec(32'h144, ADD5, 0, 0, 0, 0, NOP,  32'h144, 0);

        @(negedge clk);
        rst_n = 1'b1;
        scnt = 0; fcnt = 0;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            bus.d_pc = vecs[i].pc; bus.d_inst = vecs[i].inst;
            bus.d_valid = vecs[i].valid; bus.x_br_taken = vecs[i].br;
            #1;
            chk($sformatf("v%0d stall", i),    bus.stall,    vecs[i].e_stall);
            chk($sformatf("v%0d flush_fd", i), bus.flush_fd, vecs[i].e_flush);
            if (vecs[i].e_stall) scnt++;
            if (vecs[i].e_flush) fcnt++;
            e.inst = vecs[i].e_inst; e.pc = vecs[i].e_pc; e.valid = vecs[i].e_valid;
            e.scnt = scnt; e.fcnt = fcnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d x_inst", i),  bus.x_inst,  e.inst);
            chk($sformatf("v%0d x_pc", i),    bus.x_pc,    e.pc);
            chk($sformatf("v%0d x_valid", i), bus.x_valid, e.valid);
            chk($sformatf("v%0d fields", i),
                {bus.x_opcode, bus.x_rd, bus.x_rs1, bus.x_rs2},
                {e.inst[6:0], e.inst[11:7], e.inst[19:15], e.inst[24:20]});
            chk($sformatf("v%0d stall_cnt", i), bus.stall_cnt, e.scnt);
            chk($sformatf("v%0d flush_cnt", i), bus.flush_cnt, e.fcnt);
        end
        chk("scoreboard drained", sb.size(), 0);

        // Narrow counter: five load-use pairs must saturate at 3
        @(negedge clk);
        rst_n2 = 1'b1;
        sat_exp = 2'd0;
        for (int k = 0; k < 5; k++) begin
            bus2.d_inst = LW5; bus2.d_valid = 1'b1; bus2.d_pc = 32'h300;
            @(negedge clk);
            bus2.d_inst = ADD5; bus2.d_pc = 32'h304;
            #1;
            chk($sformatf("sat%0d stall", k), bus2.stall, 1);
            @(posedge clk);
            #1;
            if (sat_exp != 2'd3) sat_exp = sat_exp + 2'd1;
            chk($sformatf("sat%0d stall_cnt", k), bus2.stall_cnt, sat_exp);
            @(negedge clk);
            #1;
            chk($sformatf("sat%0d resolved", k), bus2.stall, 0);
            @(negedge clk);
        end

        // Reset arriving mid-stall drops stall at once and clears the counter
        bus2.d_inst = LW5; bus2.d_valid = 1'b1;
        @(negedge clk);
        bus2.d_inst = ADD5;
        #1;
        chk("pre-reset stall", bus2.stall, 1);
        rst_n2 = 1'b0;
        #1;
        chk("reset stall comb", bus2.stall, 0);
        @(posedge clk);
        #1;
        chk("reset stall_cnt", bus2.stall_cnt, 0);
        chk("reset x_valid2", bus2.x_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
